rot_share_arb: RTL and testbench
================================

Name: rot_share_arb

Overview:
- Shares one combinational W-bit right-rotator between two requesters.
- Each requester has its own valid/ready port. Arbitration is round-robin.
- The rotated result is registered into a single output slot, tagged with the requester ID, and drained through a valid/ready output handshake.
- Sits between the command sources and any consumer of rotated words.

Parameters:
W, 8, data width; must be a power of two, at least 2.
SW, $clog2(W), rotate-amount width (3 for W=8).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous, active-high reset.
req_valid  input  2  per-requester request valid; bit r = requester r.
req_data  input  2*W  operand words; requester r uses bits [r*W +: W].
req_amt  input  2*SW  rotate amounts; requester r uses bits [r*SW +: SW].
req_ready  output  2  per-requester accept; a transfer happens when req_valid[r] & req_ready[r].
out_valid  output  1  output slot holds a result.
out_data  output  W  rotated word.
out_id  output  1  requester that produced out_data.
out_ready  input  1  consumer accepts; a transfer happens when out_valid & out_ready.
grant_cnt0  output  16  number of accepted requests from requester 0; wraps.
grant_cnt1  output  16  number of accepted requests from requester 1; wraps.

Behaviour:
- Reset (rst=1 at a clock edge):
  - out_valid=0, out_data=0, out_id=0.
  - Priority pointer prio=0, so requester 0 is favoured first.
  - grant_cnt0=0, grant_cnt1=0.
  - rst overrides every concurrent event, including a mid-flight handshake: the slot is dropped and nothing is accepted that cycle.
- Rotation:
  - Right rotate: out_data[i] = operand[(i+amt) mod W].
  - amt=0 is a passthrough; amt=W-1 equals a rotate left by 1.
  - No other arithmetic; all widths are exact, with no truncation or extension.
- Slot free condition: slot_free = ~out_valid | out_ready.
  - This is combinational from out_ready, which allows full throughput of one result per cycle.
- Arbitration (combinational, from req_valid, prio and slot_free):
  - If slot_free=0, then req_ready=2'b00.
  - Else if exactly one req_valid bit is set, that bit's req_ready=1.
  - Else if both are set, req_ready[prio]=1 and the other bit is 0.
  - Else req_ready=2'b00.
  - req_ready never depends on req_data or req_amt. It may depend on req_valid.
- Accept (grant g at a clock edge):
  - out_data <= rot(req_data[g], req_amt[g]).
  - out_id <= g.
  - out_valid <= 1.
  - prio <= ~g, so the pointer moves to the other requester only on a grant.
  - grant_cnt_g increments by 1 and wraps from 0xFFFF to 0.
- Drain without a new accept (out_valid & out_ready, no grant): out_valid <= 0. out_data and out_id hold their old values.
- Drain and accept in the same cycle: the new result replaces the old one and out_valid stays 1. There is no bubble.
- Backpressure (out_valid=1, out_ready=0):
  - out_data and out_id are held stable.
  - req_ready=0 for both requesters.
  - prio and the counters hold.
- Latency: 1 cycle from the accepting edge to out_valid=1. Sustained throughput is 1 result per cycle while out_ready=1.
- Fairness: with both requesters continuously valid and out_ready=1, grants alternate 0,1,0,1,...
- A requester may change req_data or req_amt while it is not granted. The operand is sampled only on the accepting edge.

Decomposition:
- Shared package rot_pkg holds:
  - localparam ROT_W=8 and ROT_SW=3;
  - requester ID constants REQ0=1'b0 and REQ1=1'b1;
  - a typedef for the rotate-amount width.
- One sub-module, rotr_core (parameter W): purely combinational right rotator with inputs d and amt and output y.
  - Instantiated once.
  - Its input is muxed by the granted ID.

Test Plan:
- Reset, then requester 0 sends d=8'h81, amt=1, with out_ready=1 → next cycle out_valid=1, out_data=8'hC0, out_id=0; grant_cnt0=1.
- Both requesters valid from reset: r0 d=8'h96 amt=4, r1 d=8'hA5 amt=0; out_ready=1 → outputs 8'h69 (id 0), then 8'hA5 (id 1), alternating; req_ready toggles 01,10,01 across cycles.
- Backpressure: slot full with 8'h0F, out_ready=0 for 3 cycles while r1 is valid → req_ready=00; out_data stays 8'h0F. Raise out_ready → 8'h0F drains and r1 is accepted on the same edge; no idle cycle.
- Rotate sweep: d=8'h01 with amt=0..7 → outputs 8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02.
- Reset mid-operation: slot holds a result with out_ready=0; assert rst for 1 cycle with both requesters valid → out_valid=0, counters=0, no grant that cycle; the first grant after reset goes to requester 0.
- Counter wrap: force 65536 grants to requester 1 → grant_cnt1 returns to 0; grant_cnt0 is unchanged.

Source files
------------

// File: rtl/rot_pkg.sv
// Shared definitions for the rotate-share arbiter slice.
//   ROT_W / ROT_SW : default data width and rotate-amount width
//   REQ0 / REQ1    : requester ID encodings used on out_id
//   rot_amt_t      : rotate-amount type at the default width
package rot_pkg;

  localparam int ROT_W  = 8;
  localparam int ROT_SW = 3;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef logic [ROT_SW-1:0] rot_amt_t;

endpackage

// File: rtl/rotr_core.sv
// Purely combinational W-bit right rotator.
//   d   : operand word
//   amt : rotate amount, 0..W-1
//   y   : rotated word, y[i] = d[(i+amt) mod W]
module rotr_core #(
  parameter int W  = 8,
  parameter int SW = $clog2(W)
) (
  input  logic [W-1:0]  d,
  input  logic [SW-1:0] amt,
  output logic [W-1:0]  y
);

  // Doubling the word turns the rotate into a plain window select.
  logic [2*W-1:0] dd;

  always_comb begin
    dd = {d, d};
    y  = dd[amt +: W];
  end

endmodule

// File: rtl/rot_share_arb.sv
// Two-requester round-robin arbiter sharing one right rotator, with a
// single registered output slot drained by a valid/ready handshake.
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid/req_ready[1:0] : per-requester handshake
//   req_data  [2*W-1:0]      : requester r operand at [r*W +: W]
//   req_amt   [2*SW-1:0]     : requester r amount at [r*SW +: SW]
//   out_valid/out_ready      : output slot handshake
//   out_data, out_id         : rotated word and the requester it came from
//   grant_cnt0/1             : wrapping accept counters per requester
module rot_share_arb
  import rot_pkg::*;
#(
  parameter int W  = ROT_W,
  parameter int SW = $clog2(W)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid,
  input  logic [2*W-1:0]  req_data,
  input  logic [2*SW-1:0] req_amt,
  output logic [1:0]      req_ready,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic            out_id,
  input  logic            out_ready,
  output logic [15:0]     grant_cnt0,
  output logic [15:0]     grant_cnt1
);

  logic          prio;
  logic          slot_free;
  logic          grant;
  logic          gid;
  logic [W-1:0]  sel_data;
  logic [SW-1:0] sel_amt;
  logic [W-1:0]  rot_y;

  // Slot can take a new result if empty or being drained this edge.
  assign slot_free = ~out_valid | out_ready;

  // Ready is held low during reset so nothing is seen as accepted there.
  always_comb begin
    req_ready = '0;
    if (slot_free && !rst) begin
      unique case (req_valid)
        2'b01:   req_ready = 2'b01;
        2'b10:   req_ready = 2'b10;
        2'b11:   req_ready = (prio == REQ1) ? 2'b10 : 2'b01;
        default: req_ready = '0;
      endcase
    end
  end

  assign grant = |req_ready;
  assign gid   = req_ready[1] ? REQ1 : REQ0;

  always_comb begin
    sel_data = req_data[0 +: W];
    sel_amt  = req_amt[0 +: SW];
    if (gid == REQ1) begin
      sel_data = req_data[W +: W];
      sel_amt  = req_amt[SW +: SW];
    end
  end

  rotr_core #(
    .W  (W),
    .SW (SW)
  ) u_rotr (
    .d   (sel_data),
    .amt (sel_amt),
    .y   (rot_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_id     <= REQ0;
      prio       <= REQ0;
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (grant) begin
        out_data  <= rot_y;
        out_id    <= gid;
        out_valid <= 1'b1;
        prio      <= ~gid;
        if (gid == REQ1) grant_cnt1 <= grant_cnt1 + 16'd1;
        else             grant_cnt0 <= grant_cnt0 + 16'd1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rot_share_arb.sv
module tb_rot_share_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [5:0]  req_amt;
  logic [1:0]  req_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_id;
  logic        out_ready;
  logic [15:0] grant_cnt0;
  logic [15:0] grant_cnt1;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic        mv;
  logic        prio_m;
  logic [15:0] c0, c1;
  logic [8:0]  sb[$];

  always #5 clk = ~clk;

  rot_share_arb #(.W(8), .SW(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_amt    (req_amt),
    .req_ready  (req_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_id     (out_id),
    .out_ready  (out_ready),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
  );

  function automatic logic [7:0] rot_m(input logic [7:0] d, input logic [2:0] a);
    logic [7:0] r;
    for (int unsigned i = 0; i < 8; i++) r[i] = d[(i + a) % 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // One clock: check combinational outputs mid-cycle, update the model for
  // the coming edge, then return #1 after that edge.
  task automatic cycle();
    logic [1:0] er;
    logic [8:0] e;
    logic       g;
    @(negedge clk);
    er = 2'b00;
    if (!rst && (!mv || out_ready)) begin
      case (req_valid)
        2'b01:   er = 2'b01;
        2'b10:   er = 2'b10;
        2'b11:   er = prio_m ? 2'b10 : 2'b01;
        default: er = 2'b00;
      endcase
    end
    chk("req_ready", req_ready, er);
    chk("out_valid", out_valid, mv);
    chk("grant_cnt0", grant_cnt0, c0);
    chk("grant_cnt1", grant_cnt1, c1);
    if (rst) begin
      mv = 1'b0; prio_m = 1'b0; c0 = '0; c1 = '0;
      sb.delete();
    end else begin
      if (mv && out_ready) begin
        if (sb.size() == 0) begin
          chk("scoreboard_empty", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("drain_data", out_data, e[7:0]);
          chk("drain_id", out_id, e[8]);
        end
      end
      if (er != 2'b00) begin
        g = er[1];
        e = {g, rot_m(g ? req_data[15:8] : req_data[7:0], g ? req_amt[5:3] : req_amt[2:0])};
        sb.push_back(e);
        prio_m = ~g;
        if (g) c1 = c1 + 16'd1; else c0 = c0 + 16'd1;
        mv = 1'b1;
      end else if (mv && out_ready) begin
        mv = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] sweep_exp [8];
    sweep_exp = '{8'h01, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};
    mv = 1'b0; prio_m = 1'b0; c0 = '0; c1 = '0;
    rst = 1'b1; req_valid = '0; req_data = '0; req_amt = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_id", out_id, 0);
    chk("rst_cnt0", grant_cnt0, 0);
    chk("rst_cnt1", grant_cnt1, 0);
    rst = 1'b0;

    // Single request from r0
    req_valid = 2'b01; req_data = 16'h0081; req_amt = 6'd1; out_ready = 1'b1;
    cycle();
    req_valid = 2'b00;
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 8'hC0);
    chk("t1_id", out_id, 0);
    chk("t1_cnt0", grant_cnt0, 1);
    cycle();

    // Both valid from reset: alternation
    rst = 1'b1; cycle(); rst = 1'b0;
    req_valid = 2'b11; req_data = {8'hA5, 8'h96}; req_amt = {3'd0, 3'd4};
    cycle();
    chk("t2_first_data", out_data, 8'h69);
    chk("t2_first_id", out_id, 0);
    cycle();
    chk("t2_second_data", out_data, 8'hA5);
    chk("t2_second_id", out_id, 1);
    repeat (4) cycle();
    req_valid = 2'b00;
    cycle();

    // Backpressure then drain+accept on one edge
    req_valid = 2'b01; req_data = {8'h3C, 8'h0F}; req_amt = {3'd1, 3'd0}; out_ready = 1'b0;
    cycle();
    req_valid = 2'b10;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_hold_data", out_data, 8'h0F);
      chk("bp_hold_id", out_id, 0);
    end
    out_ready = 1'b1;
    cycle();
    chk("bp_accept_valid", out_valid, 1);
    chk("bp_accept_data", out_data, 8'h1E);
    chk("bp_accept_id", out_id, 1);
    req_valid = 2'b00;
    cycle();

    // Rotate sweep
    req_valid = 2'b01; req_data = 16'h0001;
    for (int a = 0; a < 8; a++) begin
      req_amt = {3'd0, 3'(a)};
      cycle();
      chk("sweep_data", out_data, sweep_exp[a]);
    end

    // Reset mid-operation with slot full and both requesters valid
    req_valid = 2'b00; out_ready = 1'b0;
    cycle();
    req_valid = 2'b11; req_data = {8'h55, 8'hAA}; req_amt = '0; rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_cnt0", grant_cnt0, 0);
    chk("midrst_cnt1", grant_cnt1, 0);
    out_ready = 1'b1;
    cycle();
    chk("midrst_first_id", out_id, 0);
    chk("midrst_first_data", out_data, 8'hAA);

    // Counter wrap on r1
    req_valid = 2'b10;
    for (int i = 0; i < 65536; i++) begin
      req_data = 16'($urandom);
      req_amt  = 6'($urandom);
      cycle();
    end
    req_valid = 2'b00;
    chk("wrap_cnt1", grant_cnt1, 0);
    chk("wrap_cnt0", grant_cnt0, 1);
    cycle();
    chk("final_empty", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
